// File: rtl/morph_window_op.sv
// rtl/morph_window_op.sv - binary morphology (dilate/erode/rank/bypass) on a KSIZE x KSIZE window
// Three-stage pipeline with frame-boundary config shadowing and a per-frame foreground counter.
module morph_window_op #(
    parameter int KSIZE = 3,
    parameter int CNT_W = 20,
    localparam int N    = KSIZE * KSIZE,
    localparam int CW   = $clog2(N + 1)
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic [N-1:0]     i_pixel_data,
    input  logic             i_pixel_data_valid,
    input  logic             i_frame_start,
    input  logic             i_cfg_wr,
    input  logic [1:0]       i_cfg_mode,
    input  logic [N-1:0]     i_cfg_mask,
    input  logic [CW-1:0]    i_cfg_thresh,
    output logic             o_convolved_data,
    output logic             o_convolved_data_valid,
    output logic [CNT_W-1:0] o_frame_count,
    output logic             o_frame_count_valid,
    output logic             o_cfg_pending
);

    localparam int HALF = N / 2;
    localparam int CTR  = (N - 1) / 2;

    localparam logic [1:0] MODE_DILATE = 2'b00;
    localparam logic [1:0] MODE_ERODE  = 2'b01;
    localparam logic [1:0] MODE_RANK   = 2'b10;

    function automatic logic [CW-1:0] popcount_range(input logic [N-1:0] v, input int lo, input int hi);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < N; i++) begin
            if (i >= lo && i < hi) c = c + CW'(v[i]);
        end
        return c;
    endfunction

    logic [1:0]    shadow_mode, active_mode;
    logic [N-1:0]  shadow_mask, active_mask;
    logic [CW-1:0] shadow_thresh, active_thresh;

    // A frame-start window consumes the shadow in the same cycle it is accepted.
    logic          apply;
    logic [1:0]    eff_mode;
    logic [N-1:0]  eff_mask;
    logic [CW-1:0] eff_thresh;

    always_comb begin
        apply      = i_pixel_data_valid & i_frame_start & o_cfg_pending;
        eff_mode   = apply ? shadow_mode   : active_mode;
        eff_mask   = apply ? shadow_mask   : active_mask;
        eff_thresh = apply ? shadow_thresh : active_thresh;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            shadow_mode   <= MODE_DILATE;
            shadow_mask   <= '1;
            shadow_thresh <= CW'(1);
            active_mode   <= MODE_DILATE;
            active_mask   <= '1;
            active_thresh <= CW'(1);
            o_cfg_pending <= 1'b0;
        end else begin
            if (apply) begin
                active_mode   <= shadow_mode;
                active_mask   <= shadow_mask;
                active_thresh <= shadow_thresh;
            end
            if (i_cfg_wr) begin
                shadow_mode   <= i_cfg_mode;
                shadow_mask   <= i_cfg_mask;
                shadow_thresh <= i_cfg_thresh;
                o_cfg_pending <= 1'b1;
            end else if (apply) begin
                o_cfg_pending <= 1'b0;
            end
        end
    end

    logic          s1_valid, s1_fs, s1_centre;
    logic [N-1:0]  s1_m;
    logic [CW-1:0] s1_mcount, s1_thresh;
    logic [1:0]    s1_mode;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            s1_valid  <= 1'b0;
            s1_fs     <= 1'b0;
            s1_centre <= 1'b0;
            s1_m      <= '0;
            s1_mcount <= '0;
            s1_thresh <= '0;
            s1_mode   <= MODE_DILATE;
        end else begin
            s1_valid  <= i_pixel_data_valid;
            s1_fs     <= i_pixel_data_valid & i_frame_start;
            s1_centre <= i_pixel_data[CTR];
            s1_m      <= i_pixel_data & eff_mask;
            s1_mcount <= popcount_range(eff_mask, 0, N);
            s1_thresh <= eff_thresh;
            s1_mode   <= eff_mode;
        end
    end

    // Adder tree split into two registered levels: half sums, then the total.
    logic          s2a_valid, s2a_fs, s2a_centre;
    logic [CW-1:0] s2a_lo, s2a_hi, s2a_mcount, s2a_thresh;
    logic [1:0]    s2a_mode;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            s2a_valid  <= 1'b0;
            s2a_fs     <= 1'b0;
            s2a_centre <= 1'b0;
            s2a_lo     <= '0;
            s2a_hi     <= '0;
            s2a_mcount <= '0;
            s2a_thresh <= '0;
            s2a_mode   <= MODE_DILATE;
        end else begin
            s2a_valid  <= s1_valid;
            s2a_fs     <= s1_fs;
            s2a_centre <= s1_centre;
            s2a_lo     <= popcount_range(s1_m, 0, HALF);
            s2a_hi     <= popcount_range(s1_m, HALF, N);
            s2a_mcount <= s1_mcount;
            s2a_thresh <= s1_thresh;
            s2a_mode   <= s1_mode;
        end
    end

    logic          s2b_valid, s2b_fs, s2b_centre;
    logic [CW-1:0] s2b_pcount, s2b_mcount, s2b_thresh;
    logic [1:0]    s2b_mode;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            s2b_valid  <= 1'b0;
            s2b_fs     <= 1'b0;
            s2b_centre <= 1'b0;
            s2b_pcount <= '0;
            s2b_mcount <= '0;
            s2b_thresh <= '0;
            s2b_mode   <= MODE_DILATE;
        end else begin
            s2b_valid  <= s2a_valid;
            s2b_fs     <= s2a_fs;
            s2b_centre <= s2a_centre;
            s2b_pcount <= s2a_lo + s2a_hi;
            s2b_mcount <= s2a_mcount;
            s2b_thresh <= s2a_thresh;
            s2b_mode   <= s2a_mode;
        end
    end

    logic result;

    always_comb begin
        result = 1'b0;
        case (s2b_mode)
            MODE_DILATE: result = (s2b_pcount != '0);
            MODE_ERODE:  result = (s2b_pcount == s2b_mcount);
            MODE_RANK:   result = (s2b_pcount >= s2b_thresh);
            default:     result = s2b_centre;
        endcase
    end

    logic [CNT_W-1:0] acc;
    logic             frame_seen;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_convolved_data       <= 1'b0;
            o_convolved_data_valid <= 1'b0;
            o_frame_count          <= '0;
            o_frame_count_valid    <= 1'b0;
            acc                    <= '0;
            frame_seen             <= 1'b0;
        end else begin
            o_convolved_data       <= s2b_valid & result;
            o_convolved_data_valid <= s2b_valid;
            o_frame_count_valid    <= 1'b0;
            if (s2b_valid) begin
                if (s2b_fs) begin
                    // The frame-start pixel belongs to the new frame, not the reported one.
                    if (frame_seen) begin
                        o_frame_count       <= acc;
                        o_frame_count_valid <= 1'b1;
                    end
                    acc        <= CNT_W'(result);
                    frame_seen <= 1'b1;
                end else if (result && acc != '1) begin
                    acc <= acc + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_morph_window_op.sv
// tb/tb_morph_window_op.sv - directed self-checking bench for morph_window_op
module tb_morph_window_op;

    localparam int KSIZE = 3;
    localparam int N     = 9;
    localparam int CW    = 4;
    localparam int CNT_W = 20;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic [N-1:0]     pixel = '0;
    logic             pvalid = 1'b0;
    logic             fs = 1'b0;
    logic             cfg_wr = 1'b0;
    logic [1:0]       cfg_mode = '0;
    logic [N-1:0]     cfg_mask = '0;
    logic [CW-1:0]    cfg_thresh = '0;
    logic             odata, ovalid, fcv, pending;
    logic [CNT_W-1:0] fcount;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;

    logic out_q[$];
    int   out_cyc_q[$];
    int   fc_q[$];
    int   fc_cyc_q[$];

    morph_window_op #(.KSIZE(KSIZE), .CNT_W(CNT_W)) dut (
        .i_clk                  (clk),
        .i_rstn                 (rstn),
        .i_pixel_data           (pixel),
        .i_pixel_data_valid     (pvalid),
        .i_frame_start          (fs),
        .i_cfg_wr               (cfg_wr),
        .i_cfg_mode             (cfg_mode),
        .i_cfg_mask             (cfg_mask),
        .i_cfg_thresh           (cfg_thresh),
        .o_convolved_data       (odata),
        .o_convolved_data_valid (ovalid),
        .o_frame_count          (fcount),
        .o_frame_count_valid    (fcv),
        .o_cfg_pending          (pending)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (ovalid) begin
            out_q.push_back(odata);
            out_cyc_q.push_back(cyc);
        end
        if (fcv) begin
            fc_q.push_back(int'(fcount));
            fc_cyc_q.push_back(cyc);
        end
    end

    task automatic clear_q();
        out_q.delete();
        out_cyc_q.delete();
        fc_q.delete();
        fc_cyc_q.delete();
    endtask

    task automatic do_reset();
        rstn   = 1'b0;
        pvalid = 1'b0;
        fs     = 1'b0;
        cfg_wr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        clear_q();
    endtask

    task automatic set_cfg(input logic [1:0] mode, input logic [N-1:0] mask, input logic [CW-1:0] th);
        cfg_mode   = mode;
        cfg_mask   = mask;
        cfg_thresh = th;
        cfg_wr     = 1'b1;
    endtask

    task automatic drive(input logic [N-1:0] w, input logic f);
        pixel  = w;
        fs     = f;
        pvalid = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        pvalid  = 1'b0;
        fs      = 1'b0;
        cfg_wr  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cfg_wr = 1'b0;
        end
    endtask

    task automatic check_outputs(input string name, input logic exp[$]);
        checks++;
        if (out_q.size() != exp.size()) begin
            errors++;
            $display("FAIL %s count: got %0d want %0d", name, out_q.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                checks++;
                if (out_q[i] !== exp[i]) begin
                    errors++;
                    $display("FAIL %s[%0d]: got %0b want %0b", name, i, out_q[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        #3;
        checks++;
        if ({ovalid, odata, fcv, pending} !== 4'b0 || fcount !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b d=%b fcv=%b p=%b fc=%0d want all 0",
                     ovalid, odata, fcv, pending, fcount);
        end
        do_reset();
    endtask

    task automatic test_default();
        int first_cyc;
        logic exp[$];
        do_reset();
        drive(9'h000, 1'b1);
        first_cyc = acc_cyc;
        drive(9'h010, 1'b0);
        drive(9'h1FF, 1'b0);
        idle(6);
        exp = '{1'b0, 1'b1, 1'b1};
        check_outputs("default_dilate", exp);
        if (out_cyc_q.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (out_cyc_q[i] !== first_cyc + 3 + i) begin
                    errors++;
                    $display("FAIL latency[%0d]: got cycle %0d want %0d", i, out_cyc_q[i], first_cyc + 3 + i);
                end
            end
        end
    endtask

    task automatic test_cfg_shadow();
        logic exp[$];
        do_reset();
        drive(9'h000, 1'b1);
        set_cfg(2'b01, 9'h0BA, 4'd1);
        idle(1);
        checks++;
        if (pending !== 1'b1) begin
            errors++;
            $display("FAIL pending_rise: got %b want 1", pending);
        end
        drive(9'h0BA, 1'b0);
        drive(9'h0B8, 1'b0);
        drive(9'h0BA, 1'b1);
        checks++;
        if (pending !== 1'b0) begin
            errors++;
            $display("FAIL pending_fall: got %b want 0", pending);
        end
        drive(9'h0B8, 1'b0);
        // bypass staged, then overwritten in the same cycle it is applied
        set_cfg(2'b11, 9'h000, 4'd1);
        idle(1);
        set_cfg(2'b00, 9'h1FF, 4'd1);
        drive(9'h010, 1'b1);
        checks++;
        if (pending !== 1'b1) begin
            errors++;
            $display("FAIL pending_same_cycle: got %b want 1", pending);
        end
        drive(9'h1EF, 1'b0);
        drive(9'h001, 1'b1);
        idle(6);
        exp = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        check_outputs("cfg_shadow", exp);
        checks++;
        if (pending !== 1'b0) begin
            errors++;
            $display("FAIL pending_final: got %b want 0", pending);
        end
    endtask

    task automatic test_rank();
        logic exp[$];
        do_reset();
        set_cfg(2'b10, 9'h1FF, 4'd5);
        idle(1);
        drive(9'h000, 1'b1);
        drive(9'h00F, 1'b0);
        drive(9'h01F, 1'b0);
        drive(9'h1FF, 1'b0);
        set_cfg(2'b10, 9'h1FF, 4'd0);
        idle(1);
        drive(9'h000, 1'b1);
        set_cfg(2'b10, 9'h1FF, 4'd10);
        idle(1);
        drive(9'h1FF, 1'b1);
        idle(6);
        exp = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        check_outputs("rank", exp);
    endtask

    task automatic test_bypass();
        logic exp[$];
        do_reset();
        set_cfg(2'b11, 9'h000, 4'd1);
        idle(1);
        drive(9'h010, 1'b1);
        idle(1);
        drive(9'h1EF, 1'b0);
        idle(6);
        exp = '{1'b1, 1'b0};
        check_outputs("bypass", exp);
    endtask

    task automatic test_frame_count();
        logic [N-1:0] f1[6];
        logic [N-1:0] f2[6];
        int f2_start;
        f1 = '{9'h001, 9'h001, 9'h000, 9'h001, 9'h000, 9'h001};
        f2 = '{9'h001, 9'h000, 9'h000, 9'h000, 9'h001, 9'h000};
        do_reset();
        for (int i = 0; i < 6; i++) drive(f1[i], i == 0);
        idle(2);
        for (int i = 0; i < 6; i++) begin
            drive(f2[i], i == 0);
            if (i == 0) f2_start = acc_cyc;
        end
        drive(9'h000, 1'b1);
        idle(6);
        checks++;
        if (fc_q.size() != 2) begin
            errors++;
            $display("FAIL frame_pulses: got %0d want 2", fc_q.size());
        end else begin
            checks++;
            if (fc_q[0] !== 4) begin
                errors++;
                $display("FAIL frame2_count: got %0d want 4", fc_q[0]);
            end
            checks++;
            if (fc_q[1] !== 2) begin
                errors++;
                $display("FAIL frame3_count: got %0d want 2", fc_q[1]);
            end
            checks++;
            if (fc_cyc_q[0] !== f2_start + 3) begin
                errors++;
                $display("FAIL frame_pulse_align: got cycle %0d want %0d", fc_cyc_q[0], f2_start + 3);
            end
        end
        checks++;
        if (fcount !== CNT_W'(2)) begin
            errors++;
            $display("FAIL frame_count_hold: got %0d want 2", fcount);
        end
    endtask

    task automatic test_reset_midflight();
        logic exp[$];
        do_reset();
        set_cfg(2'b01, 9'h0BA, 4'd1);
        idle(1);
        for (int i = 0; i < 4; i++) drive(9'h1FF, 1'b0);
        rstn = 1'b0;
        #1;
        checks++;
        if ({ovalid, odata, pending} !== 3'b000) begin
            errors++;
            $display("FAIL midflight_reset: got v=%b d=%b p=%b want 000", ovalid, odata, pending);
        end
        idle(2);
        rstn = 1'b1;
        clear_q();
        idle(6);
        checks++;
        if (out_q.size() != 0) begin
            errors++;
            $display("FAIL no_valid_after_reset: got %0d outputs want 0", out_q.size());
        end
        drive(9'h0B8, 1'b1);
        idle(6);
        exp = '{1'b1};
        check_outputs("post_reset_default", exp);
    endtask

    initial begin
        test_reset();
        test_default();
        test_cfg_shadow();
        test_rank();
        test_bypass();
        test_frame_count();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
